// File: rtl/div_pkg.sv
// Shared definitions for the multicycle divider: sequencer states and sizing constants.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift remainder:quotient left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   dvsr,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - dvsr;
        ge      = (shifted >= dvsr);
        // The kept remainder is always below the divisor, so it fits back into WIDTH bits.
        rem_nxt = WIDTH'(ge ? diff : shifted);
        quo_nxt = {quo[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed 32-bit restoring divider: LO = quotient, HI = remainder.
// Optional macro DIV_UNSIGNED_EN adds the divu input selecting an unsigned divide.
module div_unit #(
    parameter int WIDTH = div_pkg::WIDTH,
    parameter int ITER  = div_pkg::ITER
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dloadab,
    input  logic             div,
`ifdef DIV_UNSIGNED_EN
    input  logic             divu,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divzero
);
    import div_pkg::*;

    localparam int CNT_W = $clog2(ITER);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH:0]     dvsr_q;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               sign_q;
    logic               sign_r;
    logic               sgn_mode;
    logic               idle;
    logic               load;
    logic               start;
    logic               zero_req;

`ifdef DIV_UNSIGNED_EN
    assign sgn_mode = ~divu;
`else
    assign sgn_mode = 1'b1;
`endif

    // Absolute value widened by one bit so that |0x80000000| = 2^31 stays exact.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        if (sgn && sv < 0)
            return {1'b0, unsigned'(-sv)};
        return {1'b0, v};
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        return neg ? unsigned'(-sv) : v;
    endfunction

    assign idle     = (state_q == IDLE);
    assign load     = idle & dloadab;
    assign start    = idle & div & ~dloadab & (b_q != '0);
    assign zero_req = idle & div & ~dloadab & (b_q == '0);
    assign busy     = ~idle;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .dvsr    (dvsr_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        a_q     <= a;
                        b_q     <= b;
                        divzero <= 1'b0;
                    end else if (zero_req) begin
                        divzero <= 1'b1;
                    end else if (start) begin
                        rem_q   <= '0;
                        quo_q   <= WIDTH'(magnitude(a_q, sgn_mode));
                        dvsr_q  <= magnitude(b_q, sgn_mode);
                        sign_q  <= sgn_mode & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        sign_r  <= sgn_mode & a_q[WIDTH-1];
                        cnt_q   <= '0;
                        divzero <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    lo   <= apply_sign(quo_q, sign_q);
                    hi   <= apply_sign(rem_q, sign_r);
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit: driver queues expected HI/LO, monitor checks on done.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dloadab;
    logic        div;
`ifdef DIV_UNSIGNED_EN
    logic        divu;
`endif
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divzero;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dloadab (dloadab),
        .div     (div),
`ifdef DIV_UNSIGNED_EN
        .divu    (divu),
`endif
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .divzero (divzero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation, 34 edges after issue.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("lo", lo, mon_e.lo);
                check("hi", hi, mon_e.hi);
                check("latency", cyc - mon_e.t0, 32'd34);
                check("divzero_on_done", {31'd0, divzero}, 32'd0);
                check("busy_on_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic load(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        dloadab = 1'b1;
        @(negedge clk);
        dloadab = 1'b0;
    endtask

    task automatic start(input logic [31:0] elo, input logic [31:0] ehi);
        div = 1'b1;
        exp_q.push_back('{lo: elo, hi: ehi, t0: cyc});
        @(negedge clk);
        div = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic do_div(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] elo, input logic [31:0] ehi);
        load(x, y);
        start(elo, ehi);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        dloadab = 1'b0;
        div     = 1'b0;
`ifdef DIV_UNSIGNED_EN
        divu    = 1'b0;
`endif
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_divzero", {31'd0, divzero}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_div(32'd100, 32'd7, 32'd14, 32'd2);
        do_div(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
        do_div(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);

        // Divide by zero: flag set next cycle, no done, results held, cleared by a load
        load(32'd5, 32'd0);
        div = 1'b1;
        @(negedge clk);
        div = 1'b0;
        check("dz_flag", {31'd0, divzero}, 32'd1);
        check("dz_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("dz_hold", {31'd0, divzero}, 32'd1);
        check("dz_lo_kept", lo, 32'hFFFFFFF2);
        check("dz_hi_kept", hi, 32'd2);
        load(32'd9, 32'd3);
        check("dz_cleared", {31'd0, divzero}, 32'd0);

        // Load and div together: load wins, no divide starts
        load(32'd5, 32'd0);
        div = 1'b1;
        @(negedge clk);
        div = 1'b0;
        check("dz_flag2", {31'd0, divzero}, 32'd1);
        a = 32'd20;
        b = 32'd6;
        dloadab = 1'b1;
        div = 1'b1;
        @(negedge clk);
        dloadab = 1'b0;
        div = 1'b0;
        check("loadwins_divzero", {31'd0, divzero}, 32'd0);
        check("loadwins_busy", {31'd0, busy}, 32'd0);
        start(32'd3, 32'd2);
        wait_done();

        do_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        do_div(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
        do_div(32'd7, 32'd100, 32'd0, 32'd7);
        do_div(32'd0, 32'd5, 32'd0, 32'd0);

        // Load and div while busy are ignored; latched operands survive
        load(32'd100, 32'd7);
        start(32'd14, 32'd2);
        repeat (5) @(negedge clk);
        a = 32'd1;
        b = 32'd1;
        dloadab = 1'b1;
        div = 1'b1;
        @(negedge clk);
        dloadab = 1'b0;
        div = 1'b0;
        check("busy_ignore", {31'd0, busy}, 32'd1);
        wait_done();
        start(32'd14, 32'd2);
        wait_done();

        // Asynchronous reset mid-calculation aborts the divide
        load(32'd100, 32'd7);
        start(32'd14, 32'd2);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_divzero", {31'd0, divzero}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_div(32'd9, 32'd2, 32'd4, 32'd1);

`ifdef DIV_UNSIGNED_EN
        load(32'hFFFFFFFF, 32'd2);
        divu = 1'b1;
        start(32'h7FFFFFFF, 32'd1);
        divu = 1'b0;
        wait_done();
        do_div(32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
